// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel synchroniser, saturating stability counter
// against a shared runtime threshold, and registered rise/fall event pulses.
module debouncer_multi #(
  parameter int                  CHANNELS    = 4,
  parameter int                  CNT_WIDTH   = 16,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  signal_in,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic [CHANNELS-1:0]  signal_out,
  output logic [CHANNELS-1:0]  rise_pulse,
  output logic [CHANNELS-1:0]  fall_pulse,
  output logic [CHANNELS-1:0]  stable,
  output logic                 any_event
);

  // Restart on a level change, count up to the threshold, then hold (never wraps).
  function automatic logic [CNT_WIDTH-1:0] cnt_step(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic [CNT_WIDTH-1:0] thr,
    input logic                 restart
  );
    if (restart)
      return '0;
    else if (cnt < thr)
      return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else
      return cnt;
  endfunction

  logic [CHANNELS-1:0] sync_p0 [SYNC_STAGES];

  // Synchroniser stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_p0[k] <= RESET_VALUE;
    end else begin
      sync_p0[0] <= signal_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_p0[k] <= sync_p0[k-1];
    end
  end

  // Per-channel history, counter, debounced level and event pulses
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                 s;
    logic                 hist_p1;
    logic [CNT_WIDTH-1:0] cnt_p1;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 upd;
    logic                 out_p1;
    logic                 rise_p1;
    logic                 fall_p1;
    logic                 stable_p1;

    assign s = sync_p0[SYNC_STAGES-1][i];

    always_comb begin
      cnt_nxt = cnt_step(cnt_p1, threshold, s != hist_p1);
      upd     = (s == hist_p1) && (cnt_p1 >= threshold);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist_p1   <= RESET_VALUE[i];
        cnt_p1    <= '0;
        out_p1    <= RESET_VALUE[i];
        rise_p1   <= 1'b0;
        fall_p1   <= 1'b0;
        stable_p1 <= 1'b0;
      end else begin
        hist_p1   <= s;
        cnt_p1    <= cnt_nxt;
        stable_p1 <= (cnt_nxt >= threshold);
        // An unchanged rewrite after a rejected glitch produces no pulse.
        rise_p1   <= upd && s && !out_p1;
        fall_p1   <= upd && !s && out_p1;
        if (upd)
          out_p1 <= s;
      end
    end

    assign signal_out[i] = out_p1;
    assign rise_pulse[i] = rise_p1;
    assign fall_pulse[i] = fall_p1;
    assign stable[i]     = stable_p1;
  end

  assign any_event = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: vector table plus hand-written saturation
// and mid-count reset sequences.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] signal_in;
  logic [7:0] threshold;
  logic [3:0] signal_out, rise_pulse, fall_pulse, stable;
  logic       any_event;

  int tests = 0;
  int fails = 0;

  debouncer_multi #(
    .CHANNELS(4), .CNT_WIDTH(8), .SYNC_STAGES(2), .RESET_VALUE(4'b0100)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .threshold(threshold),
    .signal_out(signal_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .stable(stable), .any_event(any_event)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sin;
    logic [7:0] thr;
    int         edges;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] stb;
    logic       any;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // sin, thr, edges, out, rise, fall, stable, any
    tbl[0]  = '{4'b0100, 8'd3,   0,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0100, 8'd3,   2,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0100, 8'd3,   2,  4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[3]  = '{4'b0101, 8'd3,   5,  4'b0100, 4'b0000, 4'b0000, 4'b1110, 1'b0};
    tbl[4]  = '{4'b0101, 8'd3,   1,  4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[5]  = '{4'b0101, 8'd3,   1,  4'b0101, 4'b0001, 4'b0000, 4'b1111, 1'b1};
    tbl[6]  = '{4'b0101, 8'd3,   1,  4'b0101, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[7]  = '{4'b0111, 8'd3,   3,  4'b0101, 4'b0000, 4'b0000, 4'b1101, 1'b0};
    tbl[8]  = '{4'b0101, 8'd3,   3,  4'b0101, 4'b0000, 4'b0000, 4'b1101, 1'b0};
    tbl[9]  = '{4'b0101, 8'd3,   5,  4'b0101, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[10] = '{4'b0111, 8'd3,   5,  4'b0101, 4'b0000, 4'b0000, 4'b1101, 1'b0};
    tbl[11] = '{4'b0101, 8'd3,   2,  4'b0111, 4'b0010, 4'b0000, 4'b1111, 1'b1};
    tbl[12] = '{4'b0101, 8'd3,   1,  4'b0111, 4'b0000, 4'b0000, 4'b1101, 1'b0};
    tbl[13] = '{4'b0101, 8'd3,   3,  4'b0111, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[14] = '{4'b0101, 8'd3,   1,  4'b0101, 4'b0000, 4'b0010, 4'b1111, 1'b1};
    tbl[15] = '{4'b1001, 8'd3,   5,  4'b0101, 4'b0000, 4'b0000, 4'b0011, 1'b0};
    tbl[16] = '{4'b1001, 8'd3,   1,  4'b0101, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[17] = '{4'b1001, 8'd3,   1,  4'b1001, 4'b1000, 4'b0100, 4'b1111, 1'b1};
    tbl[18] = '{4'b1001, 8'd3,   1,  4'b1001, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[19] = '{4'b1000, 8'd0,   2,  4'b1001, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[20] = '{4'b1000, 8'd0,   1,  4'b1001, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[21] = '{4'b1000, 8'd0,   1,  4'b1000, 4'b0000, 4'b0001, 4'b1111, 1'b1};
    tbl[22] = '{4'b1000, 8'd0,   1,  4'b1000, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    tbl[23] = '{4'b1001, 8'd200, 13, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[24] = '{4'b1001, 8'd5,   1,  4'b1001, 4'b0001, 4'b0000, 4'b1111, 1'b1};
    tbl[25] = '{4'b1001, 8'd5,   1,  4'b1001, 4'b0000, 4'b0000, 4'b1111, 1'b0};

    rst       = 1'b1;
    signal_in = 4'b0100;
    threshold = 8'd3;
    step(3);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      signal_in = tbl[i].sin;
      threshold = tbl[i].thr;
      if (tbl[i].edges > 0) step(tbl[i].edges);
      chk($sformatf("row%0d out/rise/fall/stable/any", i),
          {15'd0, signal_out, rise_pulse, fall_pulse, stable, any_event},
          {15'd0, tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].stb, tbl[i].any});
    end

    // Saturation at the maximum threshold: counter must hold, never wrap.
    threshold = 8'd255;
    step(10);
    chk("sat_not_yet_stable", {28'd0, stable}, 32'd0);
    step(240);
    chk("sat_stable_out", {24'd0, stable, signal_out}, {24'd0, 4'b1111, 4'b1001});
    begin
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < 300; k++) begin
        step(1);
        if (stable !== 4'b1111 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000 ||
            signal_out !== 4'b1001)
          bad = 1'b1;
      end
      chk("sat_hold_300", {31'd0, bad}, 32'd0);
    end

    // Reset asserted while channel 0 is mid-count.
    threshold = 8'd3;
    signal_in = 4'b1000;
    step(4);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {15'd0, signal_out, rise_pulse, fall_pulse, stable, any_event},
        {15'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    signal_in = 4'b0100;
    step(2);
    rst = 1'b0;
    begin
      logic [8:0] acc;
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        step(1);
        acc = acc | {rise_pulse, fall_pulse, any_event};
      end
      chk("rst_no_pulses", {23'd0, acc}, 32'd0);
    end
    chk("rst_final_out_stable", {24'd0, signal_out, stable}, {24'd0, 4'b0100, 4'b1111});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
